// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter: enable, direction, parallel load
// and the count/terminal-count/wrap results.
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    // Controller side: drives enable, direction and load, observes the count.
    modport master (
        output en, up_dn, load, din,
        input  count, tc, wrap
    );

    // Counter side: consumes the controls, produces the count and flags.
    modport slave (
        input  en, up_dn, load, din,
        output count, tc, wrap
    );
endinterface

// File: rtl/updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous parallel load.
// Priority on each edge: reset, then load, then count enable, then hold.
// tc is combinational so stages can be cascaded as tc -> next stage en.
// wrap is a registered one-cycle pulse following a wrap-around.
module updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic              clk,
    input  logic              reset,
    updown_counter_if.slave   bus
);

    // Highest legal count value, and the modulus widened by one bit so that
    // MODULUS = 2^WIDTH is still representable for the load range check.
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_WIDE  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             din_in_range_s;

    assign din_in_range_s = ({1'b0, bus.din} < MOD_WIDE);

    // Next-state: load (clamped to range) wins over counting; counting wraps
    // modulo MODULUS and flags the wrap for one cycle.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            if (din_in_range_s) begin
                count_d = bus.din;
            end else begin
                count_d = ZERO;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (count_q == MAX_COUNT) begin
                    count_d = ZERO;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == ZERO) begin
                    count_d = MAX_COUNT;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end else begin
            count_d = count_q;
            wrap_d  = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= ZERO;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.tc    = bus.en & (bus.up_dn ? (count_q == MAX_COUNT) : (count_q == ZERO));

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed vector table on the
// decimal (MODULUS=10) counter, hand-written binary-modulus sequence, and
// randomized stimulus against an arithmetic reference model on both configs.
module tb_updown_counter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    updown_counter_if #(.WIDTH(4)) b10 ();
    updown_counter_if #(.WIDTH(4)) b16 ();

    updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (b10)
    );

    updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16)
    );

    typedef struct {
        int rst;
        int ld;
        int en;
        int up;
        int din;
        int cnt;
        int wr;
        int tc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input int rst, ld, en, up, din, cnt, wr, tc);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en; v.up = up;
        v.din = din; v.cnt = cnt; v.wr = wr; v.tc = tc;
        vecs.push_back(v);
    endtask

    // Reference model: plain integer arithmetic modulo the modulus.
    task automatic model(input int modulus, input int rst, ld, en, up, din,
                         input int cnt_in, output int cnt_out, output int wr_out);
        int t;
        if (rst == 0) begin
            cnt_out = 0;
            wr_out  = 0;
        end else if (ld != 0) begin
            cnt_out = (din < modulus) ? din : 0;
            wr_out  = 0;
        end else if (en != 0) begin
            t       = (up != 0) ? cnt_in + 1 : cnt_in - 1;
            wr_out  = (t < 0 || t >= modulus) ? 1 : 0;
            cnt_out = (t + modulus) % modulus;
        end else begin
            cnt_out = cnt_in;
            wr_out  = 0;
        end
    endtask

    function automatic int model_tc(input int modulus, en, up, cnt);
        if (en == 0) return 0;
        return (up != 0) ? int'(cnt == modulus - 1) : int'(cnt == 0);
    endfunction

    initial begin
        int m10, m16, w10, w16;
        int rst, ld, en, up, din;

        reset    = 1'b0;
        b10.en   = 1'b0; b10.up_dn = 1'b0; b10.load = 1'b0; b10.din = 4'd0;
        b16.en   = 1'b0; b16.up_dn = 1'b0; b16.load = 1'b0; b16.din = 4'd0;

        // ---------------- directed table (MODULUS = 10) ----------------
        //    rst ld en up din  cnt wr tc
        addv(0, 0, 0, 0, 0,   0, 0, 0);              // reset
        for (int i = 1; i <= 12; i++) begin          // up count 1..9,0,1,2
            addv(1, 0, 1, 1, 0, i % 10, (i == 10) ? 1 : 0, (i == 9) ? 1 : 0);
        end
        addv(1, 1, 0, 0, 2,   2, 0, 0);              // load 2
        addv(1, 0, 1, 0, 0,   1, 0, 0);              // down
        addv(1, 0, 1, 0, 0,   0, 0, 1);
        addv(1, 0, 1, 0, 0,   9, 1, 0);              // 0 -> 9 wraps
        addv(1, 0, 1, 0, 0,   8, 0, 0);
        addv(1, 1, 0, 0, 12,  0, 0, 0);              // clamp out-of-range load
        addv(1, 1, 1, 1, 7,   7, 0, 0);              // load beats en
        addv(1, 1, 0, 0, 5,   5, 0, 0);              // direction flip from 5
        addv(1, 0, 1, 1, 0,   6, 0, 0);
        addv(1, 0, 1, 0, 0,   5, 0, 0);
        addv(1, 0, 1, 1, 0,   6, 0, 0);
        addv(1, 0, 1, 0, 0,   5, 0, 1'b0);
        addv(1, 1, 0, 0, 8,   8, 0, 0);              // reset mid-operation
        addv(0, 1, 1, 1, 3,   0, 0, 0);
        addv(1, 0, 1, 1, 0,   1, 0, 0);
        addv(1, 0, 1, 1, 0,   2, 0, 0);
        addv(1, 0, 0, 1, 0,   2, 0, 0);              // hold
        addv(1, 1, 0, 0, 9,   9, 0, 0);
        addv(1, 1, 1, 1, 4,   4, 0, 0);              // load at 9 with en: no wrap
        addv(1, 1, 0, 0, 9,   9, 0, 0);
        addv(1, 0, 1, 1, 0,   0, 1, 0);              // wrap pulse
        addv(1, 0, 0, 1, 0,   0, 0, 0);              // pulse lasts one cycle

        foreach (vecs[i]) begin
            reset     = vecs[i].rst[0];
            b10.load  = vecs[i].ld[0];
            b10.en    = vecs[i].en[0];
            b10.up_dn = vecs[i].up[0];
            b10.din   = vecs[i].din[3:0];
            step();
            chk($sformatf("vec%0d_count", i), int'(b10.count), vecs[i].cnt);
            chk($sformatf("vec%0d_wrap", i),  int'(b10.wrap),  vecs[i].wr);
            chk($sformatf("vec%0d_tc", i),    int'(b10.tc),    vecs[i].tc);
        end

        // -------------- binary modulus sequence (MODULUS = 16) --------------
        chk("m16_idle_count", int'(b16.count), 0);
        b16.en = 1'b1; b16.up_dn = 1'b0;
        #1;
        chk("m16_tc_down_at0", int'(b16.tc), 1);
        step();
        chk("m16_underflow_count", int'(b16.count), 15);
        chk("m16_underflow_wrap",  int'(b16.wrap),  1);
        chk("m16_tc_down_at15",    int'(b16.tc),    0);
        b16.up_dn = 1'b1;
        #1;
        chk("m16_tc_up_at15", int'(b16.tc), 1);
        step();
        chk("m16_overflow_count", int'(b16.count), 0);
        chk("m16_overflow_wrap",  int'(b16.wrap),  1);
        b16.en = 1'b0;
        step();
        chk("m16_wrap_cleared", int'(b16.wrap), 0);
        b16.load = 1'b1; b16.din = 4'd15;
        step();
        chk("m16_load15", int'(b16.count), 15);
        b16.load = 1'b0;

        // ---------------- randomized vs. reference model ----------------
        m10 = 0; m16 = 0; w10 = 0; w16 = 0;
        for (int i = 0; i < 400; i++) begin
            rst = (i == 0) ? 0 : int'($urandom_range(0, 19) != 0);
            ld  = int'($urandom_range(0, 7) == 0);
            en  = int'($urandom_range(0, 3) != 0);
            up  = int'($urandom_range(0, 1));
            din = int'($urandom_range(0, 15));
            reset = rst[0];
            b10.load = ld[0]; b10.en = en[0]; b10.up_dn = up[0]; b10.din = din[3:0];
            b16.load = ld[0]; b16.en = en[0]; b16.up_dn = up[0]; b16.din = din[3:0];
            model(10, rst, ld, en, up, din, m10, m10, w10);
            model(16, rst, ld, en, up, din, m16, m16, w16);
            step();
            chk($sformatf("rnd%0d_m10_count", i), int'(b10.count), m10);
            chk($sformatf("rnd%0d_m10_wrap", i),  int'(b10.wrap),  w10);
            chk($sformatf("rnd%0d_m10_tc", i),    int'(b10.tc),    model_tc(10, en, up, m10));
            chk($sformatf("rnd%0d_m16_count", i), int'(b16.count), m16);
            chk($sformatf("rnd%0d_m16_wrap", i),  int'(b16.wrap),  w16);
            chk($sformatf("rnd%0d_m16_tc", i),    int'(b16.tc),    model_tc(16, en, up, m16));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
